// File: rtl/frame_serializer.sv
// Frame serializer: sends SYNC_WORD then WORDS buffer words MSB first on txd, BIT_DIV clocks per bit.
// Define FRAME_SERIALIZER_PARITY_EN to append one odd-parity bit after every data word.
module frame_serializer #(
  parameter int unsigned BIT_DIV   = 8,
  parameter int unsigned WORDS     = 20,
  parameter logic [15:0] SYNC_WORD = 16'hF0A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        full,
  input  logic [15:0] rdData,
  output logic [4:0]  rdAdr,
  output logic        rdEn,
  output logic        txd,
  output logic        busy,
  output logic        done
);

`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int unsigned WB = 17;

  function automatic logic odd_parity(input logic [15:0] w);
    return ~(^w);
  endfunction
`else
  localparam int unsigned WB = 16;
`endif

  localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
  localparam logic [7:0] DIV_PRE   = 8'(BIT_DIV - 2);
  localparam logic [4:0] BIT_LAST  = 5'(WB - 1);
  localparam logic [4:0] WORD_LAST = 5'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    FETCH = 3'd2,
    LATCH = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]  warm_q, warm_d;
  logic        low_seen_q, low_seen_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  sbit_q, sbit_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  word_q, word_d;
  logic [15:0] shreg_q, shreg_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rden_q, rden_d;
  logic [4:0]  rdadr_q, rdadr_d;
  logic        rise_s;
  logic [16:0] word_s;
  logic [4:0]  nb_idx_s;

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic par_q, par_d;
  assign word_s = {shreg_q, par_q};
`else
  assign word_s = {1'b0, shreg_q};
`endif

  // A rising edge only counts once a genuinely synchronized low has been seen after reset.
  assign rise_s   = sync2_q & low_seen_q;
  assign nb_idx_s = (bit_q == 5'd0) ? 5'd0 : bit_q - 5'd1;

  // Read data is only valid during LATCH, so the first data bit is taken straight from it there.
  assign txd   = (state_q == LATCH) ? rdData[15] : txd_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdEn  = rden_q;
  assign rdAdr = rdadr_q;

  // Next-state and next-output computation for the whole frame sequencer.
  always_comb begin
    state_d    = state_q;
    sync1_d    = full;
    sync2_d    = sync1_q;
    warm_d     = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    low_seen_d = (warm_q == 2'd2) & ~sync2_q;
    div_d      = div_q;
    sbit_d     = sbit_q;
    bit_d      = bit_q;
    word_d     = word_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rden_d     = 1'b0;
    rdadr_d    = 5'd0;
`ifdef FRAME_SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = SYNC;
          busy_d  = 1'b1;
          txd_d   = SYNC_WORD[15];
          sbit_d  = 4'd15;
          div_d   = 8'd0;
          word_d  = 5'd0;
        end else begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
        end
      end
      SYNC: begin
        if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          sbit_d = sbit_q - 4'd1;
          txd_d  = SYNC_WORD[sbit_q - 4'd1];
        end else begin
          div_d = div_q + 8'd1;
          if ((sbit_q == 4'd0) && (div_q == DIV_PRE)) begin
            state_d = FETCH;
            rden_d  = 1'b1;
            rdadr_d = word_q;
          end else begin
            state_d = SYNC;
          end
        end
      end
      FETCH: begin
        state_d = LATCH;
        div_d   = 8'd0;
        bit_d   = BIT_LAST;
      end
      LATCH: begin
        state_d = SHIFT;
        shreg_d = rdData;
        txd_d   = rdData[15];
        div_d   = div_q + 8'd1;
`ifdef FRAME_SERIALIZER_PARITY_EN
        par_d   = odd_parity(rdData);
`endif
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (bit_q == 5'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q - 5'd1;
            txd_d = word_s[nb_idx_s];
          end
        end else begin
          div_d = div_q + 8'd1;
          // Next word is fetched in the last cycle of this word's final bit to keep the line gapless.
          if ((bit_q == 5'd0) && (div_q == DIV_PRE) && (word_q != WORD_LAST)) begin
            state_d = FETCH;
            rden_d  = 1'b1;
            word_d  = word_q + 5'd1;
            rdadr_d = word_q + 5'd1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      warm_q     <= 2'd0;
      low_seen_q <= 1'b0;
      div_q      <= 8'd0;
      sbit_q     <= 4'd0;
      bit_q      <= 5'd0;
      word_q     <= 5'd0;
      shreg_q    <= 16'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rden_q     <= 1'b0;
      rdadr_q    <= 5'd0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      warm_q     <= warm_d;
      low_seen_q <= low_seen_d;
      div_q      <= div_d;
      sbit_q     <= sbit_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rden_q     <= rden_d;
      rdadr_q    <= rdadr_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter: BIT_DIV, 8, clk cycles per serial bit; legal range 2..255.
REQ-002 Parameter: WORDS, 20, number of buffer words per frame; legal range 1..32.
REQ-003 Parameter: SYNC_WORD, 16'hF0A5, frame marker sent before data, MSB first.
REQ-004 Port: clk  in  1  system clock; all logic on posedge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: full  in  1  buffer-complete flag from the write-address commutator; asynchronous to this block's state.
REQ-007 Port: rdData  in  16  buffer read data; valid one clk after rdEn.
REQ-008 Port: rdAdr  out  5  buffer read address.
REQ-009 Port: rdEn  out  1  single-cycle buffer read strobe.
REQ-010 Port: txd  out  1  serial line; idle level 1.
REQ-011 Port: busy  out  1  high from frame start to end of last bit.
REQ-012 Port: done  out  1  one-cycle pulse at frame end.

Function
REQ-013 full SHALL pass through a 2-flop synchronizer; a frame starts on the synchronized 0->1 edge only.
REQ-014 States SHALL be IDLE, SYNC, FETCH, LATCH, SHIFT, DONE.
REQ-015 IDLE->SYNC on detected edge; busy rises and txd drives SYNC_WORD[15] in the same cycle, 3 clk edges after the first edge sampling full=1.
REQ-016 Each bit SHALL hold txd stable for exactly BIT_DIV clk cycles; bits are MSB first.
REQ-017 In the last cycle of SYNC bit 0, rdAdr=0 and rdEn=1 for that one cycle (FETCH); next cycle rdData is captured into the shift register (LATCH).
REQ-018 Data bits SHALL follow the sync word with no gap; word k+1 is fetched in the last cycle of word k's final bit, so the line stream is continuous.
REQ-019 rdAdr SHALL increment 0..WORDS-1, never exceed WORDS-1, and read 0 outside FETCH.
REQ-020 After the final bit of word WORDS-1: DONE for one cycle, done=1, busy=0, txd=1, then IDLE.
REQ-021 full edges arriving while busy=1 SHALL be ignored, not queued.
REQ-022 full held high across frame end SHALL NOT start a new frame; a fresh 0->1 edge is required.
REQ-023 Total frame length SHALL be (16 + WORDS*Wb)*BIT_DIV cycles, Wb = bits per word (REQ-028).

Reset
REQ-024 On rst=0: state IDLE, txd=1, busy=0, done=0, rdEn=0, rdAdr=0, synchronizer and counters cleared.
REQ-025 Reset mid-frame SHALL abort immediately; after release, no frame starts until a new full edge.
REQ-026 Reset release SHALL NOT create a spurious edge if full is already high (synchronizer clears to 0, edge detector requires a prior synchronized 0).

Configuration
REQ-027 Macro FRAME_SERIALIZER_PARITY_EN selects per-word parity.
REQ-028 Defined: each data word is followed by one odd-parity bit (17 bits/word, Wb=17); sync word carries no parity. Undefined: 16 bits/word, Wb=16, no parity logic present.

Verification
REQ-029 BIT_DIV=8, WORDS=20, RAM[i]=16'h0100+i, full pulse -> txd shows F0A5 then 0100..0113, 16*21*8=2688 busy cycles (parity off), single done pulse.
REQ-030 Second full edge at cycle 500 of a frame -> ignored; exactly one frame, rdEn pulses=20.
REQ-031 full held high 10000 cycles -> exactly one frame transmitted.
REQ-032 rst low at data word 7, bit 3 -> txd=1, busy=0 next cycle; no done; restart on next full edge begins with SYNC_WORD.
REQ-033 PARITY_EN defined, RAM[0]=16'h0001 -> parity bit 0 after word 0; RAM[1]=16'h0003 -> parity bit 1; busy=(16+20*17)*8=2848 cycles.
REQ-034 BIT_DIV=2, WORDS=1 -> continuous 32-bit stream, no idle bit between sync and data, done 64 cycles after first sync bit.
